// File: rtl/pipo_arb_pkg.sv
// Shared types for the PIPO round-robin load arbiter.
// State encoding and owner/pointer width helper.
package pipo_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FULL,
    ARB_COOL
  } arb_state_e;

  function automatic int ow_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipo_rr_load_arbiter_rr_pick.sv
// Circular priority pick starting at ptr.
// Double-width request vector, low part masked below ptr.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            any
);

  logic [2*NREQ-1:0] dbl;
  int                sel;

  // lowest set bit of the masked double vector, folded back mod NREQ
  always_comb begin
    dbl = {req, req};
    for (int i = 0; i < NREQ; i++) begin
      if (i < int'(ptr)) dbl[i] = 1'b0;
    end
    sel = 0;
    for (int i = 2*NREQ-1; i >= 0; i--) begin
      if (dbl[i]) sel = i;
    end
    if (sel >= NREQ) sel = sel - NREQ;
    any = |req;
    idx = PW'(sel);
    onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      onehot[i] = any && (i == sel);
    end
  end

endmodule

// File: rtl/pipo_rr_load_arbiter.sv
// Round-robin load arbiter for a shared PIPO holding register.
// Valid/ready output with optional settle gap after consume.
module pipo_rr_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 4,
  parameter int MIN_GAP = 0,
  localparam int PW     = ow_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic                  load,
  output logic [WIDTH-1:0]      q,
  output logic [PW-1:0]         q_owner,
  output logic                  q_valid,
  input  logic                  q_ready
);

  localparam int CW = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  arb_state_e       state_q;
  logic [WIDTH-1:0] q_q;
  logic [PW-1:0]    own_q;
  logic [PW-1:0]    ptr_q;
  logic             vld_q;
  logic [CW-1:0]    cnt_q;

  logic [NREQ-1:0]  pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             can_load;
  logic [WIDTH-1:0] sel_data;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req    (req),
    .ptr    (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // grant only when the register is free or freed this cycle
  always_comb begin
    can_load = rst_n &
      ((state_q == ARB_IDLE) |
       ((state_q == ARB_FULL) & q_ready & (MIN_GAP == 0)));
    gnt  = can_load ? pick_oh : '0;
    load = can_load & pick_any;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) sel_data = req_data[i*WIDTH +: WIDTH];
    end
  end

  // FSM, holding register, rr pointer and gap counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB_IDLE;
      q_q     <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
    end else if (load) begin
      state_q <= ARB_FULL;
      q_q     <= sel_data;
      own_q   <= pick_idx;
      vld_q   <= 1'b1;
      ptr_q   <= (pick_idx == PW'(NREQ-1)) ? '0 : pick_idx + 1'b1;
    end else begin
      unique case (state_q)
        ARB_FULL: begin
          if (q_ready) begin
            vld_q <= 1'b0;
            if (MIN_GAP > 0) begin
              state_q <= ARB_COOL;
              cnt_q   <= CW'(MIN_GAP - 1);
            end else begin
              state_q <= ARB_IDLE;
            end
          end
        end
        ARB_COOL: begin
          if (cnt_q == '0) state_q <= ARB_IDLE;
          else             cnt_q   <= cnt_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign q       = q_q;
  assign q_owner = own_q;
  assign q_valid = vld_q;

endmodule

// File: tb/tb_pipo_rr_load_arbiter.sv
// Bench for pipo_rr_load_arbiter: directed table, corner
// sequences and random traffic against a behavioural model.
module tb_pipo_rr_load_arbiter;

  localparam int N = 4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req = '0;
  logic [N*W-1:0] req_data = '0;
  logic         q_ready = 1'b0;

  logic [N-1:0] gnt0, gnt2;
  logic         load0, load2;
  logic [W-1:0] q0, q2;
  logic [1:0]   own0, own2;
  logic         vld0, vld2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipo_rr_load_arbiter #(.NREQ(N), .WIDTH(W), .MIN_GAP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt0), .load(load0), .q(q0), .q_owner(own0),
    .q_valid(vld0), .q_ready(q_ready)
  );

  pipo_rr_load_arbiter #(.NREQ(N), .WIDTH(W), .MIN_GAP(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .gnt(gnt2), .load(load2), .q(q2), .q_owner(own2),
    .q_valid(vld2), .q_ready(q_ready)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = '0;
    q_ready = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // behavioural model: state as plain flags and counters
  typedef struct {
    int gap_cfg;
    bit valid;
    int q;
    int owner;
    int ptr;
    int gap;
  } mdl_t;

  function automatic int mdl_gnt(input mdl_t m, input logic [N-1:0] r,
                                 input logic rdy);
    bit can;
    can = (!m.valid && m.gap == 0) || (m.valid && rdy && m.gap_cfg == 0);
    if (!can) return 0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m.ptr + k) % N;
      if (r[i]) return 1 << i;
    end
    return 0;
  endfunction

  function automatic mdl_t mdl_step(input mdl_t m, input logic [N-1:0] r,
                                    input logic [N*W-1:0] d, input logic rdy);
    int g;
    g = mdl_gnt(m, r, rdy);
    if (g != 0) begin
      for (int i = 0; i < N; i++) begin
        if (g == (1 << i)) begin
          m.q = int'(d[i*W +: W]);
          m.owner = i;
          m.ptr = (i + 1) % N;
        end
      end
      m.valid = 1'b1;
    end else if (m.valid && rdy) begin
      m.valid = 1'b0;
      m.gap = m.gap_cfg;
    end else if (m.gap > 0) begin
      m.gap--;
    end
    return m;
  endfunction

  function automatic mdl_t mdl_reset(input int cfg);
    mdl_t m;
    m.gap_cfg = cfg;
    m.valid = 0;
    m.q = 0;
    m.owner = 0;
    m.ptr = 0;
    m.gap = 0;
    return m;
  endfunction

  typedef struct {
    logic [N-1:0]   req;
    logic [N*W-1:0] data;
    logic           rdy;
    logic [N-1:0]   gnt;
    logic [W-1:0]   q;
    logic [1:0]     own;
    logic           vld;
  } vec_t;

  vec_t tbl[18];
  mdl_t m0, m2;

  initial begin
    // single request, consume, ignored ready
    tbl[0]  = '{4'b0001, 16'h432A, 1'b0, 4'b0001, 4'h0, 2'd0, 1'b0};
    tbl[1]  = '{4'b0000, 16'h432A, 1'b1, 4'b0000, 4'hA, 2'd0, 1'b1};
    tbl[2]  = '{4'b0000, 16'h4321, 1'b0, 4'b0000, 4'hA, 2'd0, 1'b0};
    // all requesting, back-to-back from ptr=1
    tbl[3]  = '{4'b1111, 16'h4321, 1'b1, 4'b0010, 4'hA, 2'd0, 1'b0};
    tbl[4]  = '{4'b1111, 16'h4321, 1'b1, 4'b0100, 4'h2, 2'd1, 1'b1};
    tbl[5]  = '{4'b1111, 16'h4321, 1'b1, 4'b1000, 4'h3, 2'd2, 1'b1};
    tbl[6]  = '{4'b1111, 16'h4321, 1'b1, 4'b0001, 4'h4, 2'd3, 1'b1};
    // backpressure for 5 cycles, then release
    for (int i = 7; i < 12; i++)
      tbl[i] = '{4'b0110, 16'h4321, 1'b0, 4'b0000, 4'h1, 2'd0, 1'b1};
    tbl[12] = '{4'b0110, 16'h4321, 1'b1, 4'b0010, 4'h1, 2'd0, 1'b1};
    // wrap from requester 3 back to 0
    tbl[13] = '{4'b1000, 16'h4321, 1'b1, 4'b1000, 4'h2, 2'd1, 1'b1};
    tbl[14] = '{4'b1001, 16'h4321, 1'b1, 4'b0001, 4'h4, 2'd3, 1'b1};
    tbl[15] = '{4'b0000, 16'h4321, 1'b1, 4'b0000, 4'h1, 2'd0, 1'b1};
    tbl[16] = '{4'b0000, 16'h4321, 1'b0, 4'b0000, 4'h1, 2'd0, 1'b0};
    tbl[17] = '{4'b0000, 16'h4321, 1'b1, 4'b0000, 4'h1, 2'd0, 1'b0};

    // async reset with a loaded word and ptr=2
    do_reset();
    req = 4'b0010;
    req_data = 16'h4371;
    #1;
    chk("rst_pre_gnt", gnt0, 4'b0010);
    next_cyc();
    req = '0;
    #1;
    chk("rst_pre_q", q0, 4'h7);
    chk("rst_pre_vld", vld0, 1);
    #2;
    rst_n = 1'b0;
    req = 4'b1111;
    #1;
    chk("rst_q", q0, 0);
    chk("rst_vld", vld0, 0);
    chk("rst_own", own0, 0);
    chk("rst_gnt", gnt0, 0);
    chk("rst_load", load0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_after_gnt", gnt0, 4'b0001);

    // directed table
    do_reset();
    foreach (tbl[i]) begin
      req = tbl[i].req;
      req_data = tbl[i].data;
      q_ready = tbl[i].rdy;
      #1;
      chk($sformatf("tbl%0d_gnt", i), gnt0, tbl[i].gnt);
      chk($sformatf("tbl%0d_load", i), load0, |tbl[i].gnt);
      chk($sformatf("tbl%0d_q", i), q0, tbl[i].q);
      chk($sformatf("tbl%0d_own", i), own0, tbl[i].own);
      chk($sformatf("tbl%0d_vld", i), vld0, tbl[i].vld);
      next_cyc();
    end

    // settle gap with MIN_GAP=2
    do_reset();
    req = 4'b0001;
    req_data = 16'h4325;
    #1;
    chk("gap_first_gnt", gnt2, 4'b0001);
    next_cyc();
    q_ready = 1'b1;
    #1;
    chk("gap_t_vld", vld2, 1);
    chk("gap_t_gnt", gnt2, 0);
    next_cyc();
    q_ready = 1'b0;
    #1;
    chk("gap_t1_vld", vld2, 0);
    chk("gap_t1_gnt", gnt2, 0);
    next_cyc();
    #1;
    chk("gap_t2_gnt", gnt2, 0);
    next_cyc();
    #1;
    chk("gap_t3_gnt", gnt2, 4'b0001);
    chk("gap_t3_load", load2, 1);
    next_cyc();
    #1;
    chk("gap_t4_q", q2, 4'h5);

    // random traffic against the model, both gap settings
    do_reset();
    m0 = mdl_reset(0);
    m2 = mdl_reset(2);
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        do_reset();
        m0 = mdl_reset(0);
        m2 = mdl_reset(2);
      end
      req = N'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = '0;
      req_data = (N*W)'($urandom);
      q_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd0_gnt", gnt0, mdl_gnt(m0, req, q_ready));
      chk("rnd0_load", load0, mdl_gnt(m0, req, q_ready) != 0);
      chk("rnd0_vld", vld0, m0.valid);
      chk("rnd0_q", q0, m0.q);
      chk("rnd0_own", own0, m0.owner);
      chk("rnd2_gnt", gnt2, mdl_gnt(m2, req, q_ready));
      chk("rnd2_vld", vld2, m2.valid);
      chk("rnd2_q", q2, m2.q);
      chk("rnd2_own", own2, m2.owner);
      m0 = mdl_step(m0, req, req_data, q_ready);
      m2 = mdl_step(m2, req, req_data, q_ready);
      next_cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
